// File: rtl/delta_event_packer_pkg.sv
// Shared defaults, FSM encoding and marker constant for delta_event_packer.
// The bin-marker feature is selected with the DELTA_BIN_MARKER_EN macro.
package delta_event_packer_pkg;

  localparam int CH_NUM_DEF   = 96;
  localparam int CH_BIT_DEF   = 7;
  localparam int RATE_BIT_DEF = 4;
  localparam int FIFO_AW_DEF  = 4;
  localparam int DROP_BIT_DEF = 8;

  // Delta value reserved for end-of-bin markers; real events never use it.
  localparam int MARKER_DELTA = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIN  = 2'd1,
    ST_MARK = 2'd2
  } state_t;

  function automatic logic [1:0] bit_sum2(logic a, logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/delta_event_packer_sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop and per-cycle drop reporting.
// With DELTA_BIN_MARKER_EN a second, later-ordered push port is added.
module sync_fifo
  import delta_event_packer_pkg::*;
#(
  parameter int W  = 11,
  parameter int AW = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push0_i,
  input  logic [W-1:0] data0_i,
`ifdef DELTA_BIN_MARKER_EN
  input  logic         push1_i,
  input  logic [W-1:0] data1_i,
`endif
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   drop_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW+1:0] free;
  logic          pop, acc0, acc1;

  always_comb begin
    pop  = pop_i & (cnt_q != '0);
    // A slot freed by this cycle's pop is reusable by this cycle's push.
    free = (AW+2)'(DEPTH) - (AW+2)'(cnt_q) + (AW+2)'(pop);
    acc0 = push0_i & (free != '0);
`ifdef DELTA_BIN_MARKER_EN
    acc1   = push1_i & (free >= (push0_i ? (AW+2)'(2) : (AW+2)'(1)));
    drop_o = bit_sum2(push0_i & !acc0, push1_i & !acc1);
`else
    acc1   = 1'b0;
    drop_o = bit_sum2(push0_i & !acc0, 1'b0);
`endif
    wr_d  = wr_q + AW'(acc0) + AW'(acc1);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc0) mem_q[wr_q] <= data0_i;
`ifdef DELTA_BIN_MARKER_EN
    if (acc1) mem_q[wr_q + AW'(acc0)] <= data1_i;
`endif
  end

  // Head is forced to zero when empty so stale storage never reaches the port.
  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/delta_event_packer.sv
// Delta-channel event packer: suppresses skip-rate samples, encodes {delta, mapped rate}
// into a FIFO drained over valid/ready. Optional bin markers via DELTA_BIN_MARKER_EN.
module delta_event_packer
  import delta_event_packer_pkg::*;
#(
  parameter int CH_NUM   = CH_NUM_DEF,
  parameter int CH_BIT   = CH_BIT_DEF,
  parameter int RATE_BIT = RATE_BIT_DEF,
  parameter int FIFO_AW  = FIFO_AW_DEF,
  parameter int DROP_BIT = DROP_BIT_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                bin_start,
  input  logic                in_valid,
  input  logic [CH_BIT-1:0]   in_ch,
  input  logic [RATE_BIT-1:0] in_rate,
  input  logic [RATE_BIT-1:0] in_skip_rate,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_BIT-1:0]   out_delta,
  output logic [RATE_BIT-1:0] out_rate,
  output logic                overflow,
  output logic [DROP_BIT-1:0] drop_count,
  output logic                seq_err
);

  localparam int                W         = CH_BIT + RATE_BIT;
  localparam logic [CH_BIT-1:0] LAST_INIT = CH_BIT'(CH_NUM - 1);

  function automatic logic [CH_BIT-1:0] calc_delta(logic [CH_BIT-1:0] ch,
                                                   logic [CH_BIT-1:0] base);
    logic [CH_BIT:0] ch_x, base_x, d;
    ch_x   = {1'b0, ch};
    base_x = {1'b0, base};
    if (ch > base) d = ch_x - base_x;
    else           d = ch_x + (CH_BIT+1)'(CH_NUM) - base_x;
    return CH_BIT'(d);
  endfunction

  // The skip symbol never appears, so values above it shift down by one.
  function automatic logic [RATE_BIT-1:0] map_rate(logic [RATE_BIT-1:0] rate,
                                                   logic [RATE_BIT-1:0] skip);
    return (rate > skip) ? rate - RATE_BIT'(1) : rate;
  endfunction

  function automatic logic [DROP_BIT-1:0] sat_drop(logic [DROP_BIT-1:0] a, logic [1:0] b);
    logic [DROP_BIT:0] s;
    s = {1'b0, a} + (DROP_BIT+1)'(b);
    return s[DROP_BIT] ? '1 : s[DROP_BIT-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [CH_BIT-1:0]   last_ch_q, last_ch_d, prev_ch_q, prev_ch_d;
  logic                overflow_q, overflow_d, seq_err_q, seq_err_d;
  logic [DROP_BIT-1:0] drop_q, drop_d;
  logic                start, evt, in_bin;
  logic [CH_BIT-1:0]   base, delta;
  logic [RATE_BIT-1:0] mapped;
  logic [W-1:0]        evt_word, data0, head;
  logic                push0;
  logic [1:0]          drops;
`ifdef DELTA_BIN_MARKER_EN
  logic                push1, mark_push;
  logic [W-1:0]        data1;
  logic [RATE_BIT-1:0] evt_cnt_q, evt_cnt_d;
`endif

  assign start    = in_valid & bin_start;
  assign evt      = in_valid & (in_rate != in_skip_rate);
  assign in_bin   = (state_q != ST_IDLE);
  assign base     = bin_start ? LAST_INIT : last_ch_q;
  assign delta    = calc_delta(in_ch, base);
  assign mapped   = map_rate(in_rate, in_skip_rate);
  assign evt_word = {delta, mapped};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BIN;
`ifdef DELTA_BIN_MARKER_EN
      ST_BIN:  if (start) state_d = ST_MARK;
      ST_MARK: if (!start) state_d = ST_BIN;
`else
      ST_BIN:  state_d = ST_BIN;
`endif
      default: state_d = ST_BIN;
    endcase
  end

  always_comb begin
    push0 = evt;
    data0 = evt_word;
`ifdef DELTA_BIN_MARKER_EN
    // Marker goes on port 0 so it lands ahead of the new bin's first event.
    mark_push = start & in_bin;
    push1     = 1'b0;
    data1     = evt_word;
    if (mark_push) begin
      push0 = 1'b1;
      data0 = {CH_BIT'(MARKER_DELTA), evt_cnt_q};
      push1 = evt;
    end
`endif
  end

  always_comb begin
    last_ch_d  = evt ? in_ch : last_ch_q;
    prev_ch_d  = in_valid ? in_ch : prev_ch_q;
    seq_err_d  = seq_err_q | (in_valid & !bin_start & in_bin & (in_ch <= prev_ch_q));
    overflow_d = overflow_q | (drops != 2'd0);
    drop_d     = sat_drop(drop_q, drops);
`ifdef DELTA_BIN_MARKER_EN
    evt_cnt_d = evt_cnt_q;
    if (start)                       evt_cnt_d = evt ? RATE_BIT'(1) : '0;
    else if (evt && evt_cnt_q != '1) evt_cnt_d = evt_cnt_q + RATE_BIT'(1);
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_ch_q  <= LAST_INIT;
      prev_ch_q  <= LAST_INIT;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
`ifdef DELTA_BIN_MARKER_EN
      evt_cnt_q  <= '0;
`endif
    end else begin
      last_ch_q  <= last_ch_d;
      prev_ch_q  <= prev_ch_d;
      seq_err_q  <= seq_err_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
`ifdef DELTA_BIN_MARKER_EN
      evt_cnt_q  <= evt_cnt_d;
`endif
    end
  end

  sync_fifo #(.W(W), .AW(FIFO_AW)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push0_i (push0),
    .data0_i (data0),
`ifdef DELTA_BIN_MARKER_EN
    .push1_i (push1),
    .data1_i (data1),
`endif
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .data_o  (head),
    .drop_o  (drops)
  );

  assign out_delta  = head[W-1:RATE_BIT];
  assign out_rate   = head[RATE_BIT-1:0];
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign seq_err    = seq_err_q;

endmodule

// File: doc/delta_event_packer.md
Name: delta_event_packer

Overview:
Event-driven compressor for binned multi-unit-activity rates.
- Input: one (channel, rate) sample per cycle, channels scanned in ascending order each bin.
- Suppresses samples equal to that channel's calibrated most-frequent rate ("skip rate").
- Encodes each surviving sample as {delta_channel, mapped_rate}, buffers it in a FIFO and drains it over a valid/ready interface to the downstream entropy encoder.
- Successor to the fixed-96-channel delta-channel logic: parametrised in channel count, rate width and buffer depth; adds backpressure, overflow accounting and scan-order checking.

Parameters:
- CH_NUM, 96, channels per bin.
- CH_BIT, 7, channel/delta width; must satisfy 2^CH_BIT > CH_NUM.
- RATE_BIT, 4, spike-rate width.
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW.
- DROP_BIT, 8, width of the saturating drop counter.

Ports:
- CLK, in, 1, clock; all state on rising edge.
- RST, in, 1, reset, asynchronous, active-low.
- bin_start, in, 1, qualifies the first sample of a new bin (with in_valid).
- in_valid, in, 1, sample present this cycle; no input backpressure.
- in_ch, in, CH_BIT, channel index 0..CH_NUM-1.
- in_rate, in, RATE_BIT, binned spike count.
- in_skip_rate, in, RATE_BIT, per-channel suppressed value, read from calibration RAM.
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, consumer accepts head.
- out_delta, out, CH_BIT, channel delta 1..CH_NUM (0 reserved for marker).
- out_rate, out, RATE_BIT, mapped rate.
- overflow, out, 1, sticky: event lost to full FIFO.
- drop_count, out, DROP_BIT, saturating count of lost events.
- seq_err, out, 1, sticky: out-of-order channel within a bin.

Behaviour:
- Reset: out_valid=0, out_delta=0, out_rate=0, overflow=0, drop_count=0, seq_err=0, FIFO empty, last_ch=CH_NUM-1, state IDLE.
- States:
  - IDLE -> BIN on in_valid & bin_start.
  - BIN -> BIN on further samples; a new bin_start restarts the bin.
  - MARK is used only with the optional feature.
- Delta base: bin_start forces the base to CH_NUM-1 for the qualifying sample, so channel 0 gives delta 1.
- Delta arithmetic, in CH_BIT+1 bits:
  - in_ch > base: delta = in_ch - base.
  - otherwise: delta = in_ch + CH_NUM - base.
- Event condition: in_valid & (in_rate != in_skip_rate).
  - On an event, last_ch <= in_ch.
  - A suppressed sample leaves last_ch unchanged, so deltas span skipped channels.
- Rate mapping removes the suppressed symbol:
  - in_rate < skip: mapped = in_rate.
  - in_rate > skip: mapped = in_rate - 1.
- Sequence check: in BIN, non-bin_start sample with in_ch <= previous sampled channel (event or not) -> seq_err=1. The sample is still processed.
- Latency: event written to FIFO on the sampling edge; out_valid rises the following cycle; no combinational bypass.
- Handshake:
  - Pop on out_valid & out_ready.
  - out_delta/out_rate are held stable while out_valid & !out_ready.
- Full FIFO:
  - Push with no simultaneous pop -> event dropped, overflow=1, drop_count++ (saturates at all-ones).
  - Push + pop in the same cycle when full -> push accepted.
- Empty FIFO: out_ready ignored.
- RST mid-bin: everything returns to reset values; FIFO contents discarded.

Optional Feature:
- Macro: DELTA_BIN_MARKER_EN.
- Enabled:
  - On bin_start while in BIN, a marker {delta=0, rate=number of events in the closing bin, saturated to RATE_BIT} is pushed before the new bin's first event.
  - The marker takes one extra cycle (state MARK); any event on that cycle is still pushed in order behind the marker.
  - FIFO push logic accepts two writes when two slots are free; otherwise the later write is dropped per the overflow rules.
- Disabled: no markers, no MARK state; delta 0 never appears on out_delta.

Decomposition:
- Shared package/include: CH_NUM, CH_BIT, RATE_BIT defaults; state encodings; MARKER_DELTA=0 constant.
- One sub-module: sync_fifo (parametrised width/depth, full/empty, simultaneous push-pop, up to 2 pushes per cycle under the macro).
- Delta/mapping logic stays in the top module.

Test Plan:
- Calibration skip=3 for all channels; bin with rates ch0=5, ch1..ch9=3, ch10=1, out_ready=1 -> events (delta 1, rate 4), (delta 10, rate 1); nothing else.
- Two bins: bin 1 ends with an event at ch95, bin 2 has its first event at ch2 -> delta 3 (base reset via bin_start), not wrap-derived.
- Hold out_ready=0 with FIFO_AW=4, generate 20 events -> 16 stored, overflow=1, drop_count=4; release out_ready -> 16 pops in order, payload stable while stalled.
- FIFO full, same-cycle pop and new event -> push accepted, drop_count unchanged.
- Feed in_ch 5 then 4 within a bin -> seq_err=1 and sticky; RST low mid-bin -> all outputs return to 0, out_valid=0 immediately.
- With DELTA_BIN_MARKER_EN: bin with 2 events, then bin_start with an event at ch0 -> outputs: 2 events, marker (delta 0, rate 2), (delta 1, ...).
